bus_decoder: RTL and testbench

Address decoder and watchdog sitting directly downstream of the instruction/data bus arbiter. Takes the single shared memory bus, routes each request to one of `NUM_SLAVES` slave ports by address window, and returns that slave's read data, ready and fault. It terminates unmapped or hung accesses with a fault so the core never stalls forever. It also latches the address of the last faulting access for trap handlers.

---
 rtl/bus_decoder_pkg.sv | 20 ++
 rtl/bus_watchdog.sv | 33 +++
 rtl/bus_decoder.sv | 177 +++++++++++++++++
 tb/tb_bus_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_decoder_pkg.sv
// Shared types and default address map for the bus decoder.
package bus_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam int NUM_SLAVES_DEFAULT = 4;

    localparam logic [NUM_SLAVES_DEFAULT*32-1:0] DEFAULT_SLAVE_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};

    localparam logic [NUM_SLAVES_DEFAULT*32-1:0] DEFAULT_SLAVE_MASK =
        {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/bus_watchdog.sv
// Saturating wait-cycle counter; expired flags TIMEOUT_CYCLES waits without ready.
module bus_watchdog
    import bus_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;

    // start loads 1 because the request cycle spent in IDLE already counts as a wait
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= CNT_W'(1);
        end else if (tick && (wait_cnt != LIMIT)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign expired = (wait_cnt == LIMIT);

endmodule

// File: rtl/bus_decoder.sv
// Routes the shared memory bus to one slave by address window, with watchdog
// termination of unmapped or hung accesses and a sticky fault-address record.
//
//   state   | meaning
//   IDLE    | no transfer in flight; decode address_in combinationally
//   BUSY    | waiting on latched slave sel_q
//   TIMEOUT | one-cycle forced fault completion, no slave selected
module bus_decoder
    import bus_decoder_pkg::*;
#(
    parameter int                         NUM_SLAVES     = NUM_SLAVES_DEFAULT,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = DEFAULT_SLAVE_BASE,
    parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = DEFAULT_SLAVE_MASK,
    parameter int                         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                address_in,
    input  logic                       read_in,
    input  logic                       write_in,
    input  logic [3:0]                 write_mask_in,
    input  logic [31:0]                write_value_in,
    output logic [31:0]                read_value_out,
    output logic                       ready_out,
    output logic                       fault_out,
    output logic [NUM_SLAVES-1:0]      slave_sel_out,
    output logic [31:0]                slave_address_out,
    output logic                       slave_read_out,
    output logic                       slave_write_out,
    output logic [3:0]                 slave_write_mask_out,
    output logic [31:0]                slave_write_value_out,
    input  logic [NUM_SLAVES*32-1:0]   slave_read_value_in,
    input  logic [NUM_SLAVES-1:0]      slave_ready_in,
    input  logic [NUM_SLAVES-1:0]      slave_fault_in,
    output logic [31:0]                fault_addr_out,
    output logic                       fault_valid_out
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;

    logic [NUM_SLAVES-1:0] match;
    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic                  active;

    logic             route_valid;
    logic [IDX_W-1:0] route_idx;
    logic             route_ready;

    logic wd_start, wd_clear, wd_tick, wd_expired;

    assign active = read_in || write_in;

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_match
        assign match[i] = ((address_in & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]);
    end

    // Scan high to low so the lowest matching index is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wd_start    = 1'b0;
        wd_clear    = 1'b0;
        wd_tick     = 1'b0;
        route_valid = 1'b0;
        route_idx   = sel_q;

        case (state_q)
            IDLE: begin
                route_valid = active && hit;
                route_idx   = hit_idx;
            end
            BUSY:    route_valid = active;
            default: route_valid = 1'b0;
        endcase

        route_ready = route_valid && slave_ready_in[route_idx];

        slave_sel_out   = '0;
        slave_read_out  = 1'b0;
        slave_write_out = 1'b0;
        ready_out       = 1'b0;
        fault_out       = 1'b0;
        read_value_out  = '0;

        if (route_valid) begin
            slave_sel_out   = NUM_SLAVES'(1) << route_idx;
            slave_read_out  = read_in;
            slave_write_out = write_in;
            ready_out       = route_ready;
            fault_out       = route_ready && slave_fault_in[route_idx];
            if (route_ready) begin
                read_value_out = slave_read_value_in[int'(route_idx)*32 +: 32];
            end
        end

        case (state_q)
            IDLE: begin
                if (active && !hit) begin
                    ready_out = 1'b1;
                    fault_out = 1'b1;
                end else if (route_valid && !route_ready) begin
                    state_d  = BUSY;
                    sel_d    = hit_idx;
                    wd_start = 1'b1;
                end
            end
            BUSY: begin
                if (!active || route_ready) begin
                    state_d  = IDLE;
                    wd_clear = 1'b1;
                end else if (wd_expired) begin
                    state_d  = TIMEOUT;
                    wd_clear = 1'b1;
                end else begin
                    wd_tick = 1'b1;
                end
            end
            TIMEOUT: begin
                ready_out = 1'b1;
                fault_out = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign slave_address_out     = address_in;
    assign slave_write_mask_out  = write_mask_in;
    assign slave_write_value_out = write_value_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_addr_out  <= '0;
            fault_valid_out <= 1'b0;
        end else if (ready_out && fault_out) begin
            fault_addr_out  <= address_in;
            fault_valid_out <= 1'b1;
        end
    end

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk     (clk),
        .reset   (reset),
        .start   (wd_start),
        .clear   (wd_clear),
        .tick    (wd_tick),
        .expired (wd_expired)
    );

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder with a window/age-based reference model.
module tb_bus_decoder;

    localparam int NS = 4;
    localparam int T  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address_in;
    logic        read_in, write_in;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic [31:0] read_value_out;
    logic        ready_out, fault_out;
    logic [NS-1:0] slave_sel_out;
    logic [31:0] slave_address_out;
    logic        slave_read_out, slave_write_out;
    logic [3:0]  slave_write_mask_out;
    logic [31:0] slave_write_value_out;
    logic [NS*32-1:0] slave_read_value_in;
    logic [NS-1:0] slave_ready_in, slave_fault_in;
    logic [31:0] fault_addr_out;
    logic        fault_valid_out;

    int checks = 0;
    int errors = 0;

    bus_decoder #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .address_in(address_in), .read_in(read_in), .write_in(write_in),
        .write_mask_in(write_mask_in), .write_value_in(write_value_in),
        .read_value_out(read_value_out), .ready_out(ready_out), .fault_out(fault_out),
        .slave_sel_out(slave_sel_out), .slave_address_out(slave_address_out),
        .slave_read_out(slave_read_out), .slave_write_out(slave_write_out),
        .slave_write_mask_out(slave_write_mask_out),
        .slave_write_value_out(slave_write_value_out),
        .slave_read_value_in(slave_read_value_in), .slave_ready_in(slave_ready_in),
        .slave_fault_in(slave_fault_in),
        .fault_addr_out(fault_addr_out), .fault_valid_out(fault_valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Address windows written as [base, base+size)
    logic [31:0] win_base [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    logic [31:0] win_size [NS] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_1000, 32'h0000_0100};

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if (a >= win_base[i] && (a - win_base[i]) < win_size[i]) return i;
        return -1;
    endfunction

    // Model: a transfer in flight remembers its slave and its age in cycles
    bit          m_init = 0, m_busy = 0, m_pending = 0;
    int          m_sel = 0, m_age = 0;
    logic [31:0] m_faddr = '0;
    bit          m_fvalid = 0;

    always @(negedge clk) begin
        bit          act, e_ready, e_fault;
        int          idx;
        logic [NS-1:0] e_sel;
        logic [31:0] e_data;
        act = read_in || write_in;
        e_sel = '0; e_ready = 0; e_fault = 0; e_data = '0; idx = -1;
        if (m_pending) begin
            e_ready = 1; e_fault = 1;
        end else if (act) begin
            idx = m_busy ? m_sel : decode(address_in);
            if (idx < 0) begin
                e_ready = 1; e_fault = 1;
            end else begin
                e_sel   = NS'(1) << idx;
                e_ready = slave_ready_in[idx];
                e_fault = e_ready && slave_fault_in[idx];
                e_data  = e_ready ? slave_read_value_in[idx*32 +: 32] : 32'h0;
            end
        end
        if (m_init) begin
            check("sel", 32'(slave_sel_out), 32'(e_sel));
            check("ready", 32'(ready_out), 32'(e_ready));
            check("fault", 32'(fault_out), 32'(e_fault));
            check("rdata", read_value_out, e_data);
            check("sread", 32'(slave_read_out), 32'((e_sel != 0) && read_in));
            check("swrite", 32'(slave_write_out), 32'((e_sel != 0) && write_in));
            check("saddr", slave_address_out, address_in);
            check("faddr", fault_addr_out, m_faddr);
            check("fvalid", 32'(fault_valid_out), 32'(m_fvalid));
        end
        if (reset) begin
            m_busy = 0; m_pending = 0; m_sel = 0; m_age = 0;
            m_faddr = '0; m_fvalid = 0; m_init = 1;
        end else begin
            if (e_ready && e_fault) begin m_faddr = address_in; m_fvalid = 1; end
            if (m_pending) m_pending = 0;
            else if (!act || idx < 0 || e_ready) m_busy = 0;
            else if (!m_busy) begin m_busy = 1; m_sel = idx; m_age = 1; end
            else if (m_age == T) begin m_busy = 0; m_pending = 1; end
            else m_age++;
        end
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] rdy, input logic [3:0] flt);
        read_in = rd; write_in = wr; address_in = a;
        slave_ready_in = rdy; slave_fault_in = flt;
    endtask

    task automatic idle();
        req(0, 0, 32'h0, 4'b0000, 4'b0000);
    endtask

    initial begin
        reset = 1'b1;
        write_mask_in = 4'hF; write_value_in = 32'hCAFE_0000;
        slave_read_value_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        idle();
        repeat (2) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst_sel", 32'(slave_sel_out), 32'h0);
        check("rst_ready", 32'(ready_out), 32'h0);
        check("rst_fvalid", 32'(fault_valid_out), 32'h0);
        check("rst_faddr", fault_addr_out, 32'h0);

        // Zero-latency read on slave0
        next_cycle(); req(1, 0, 32'h0000_0040, 4'b0001, 4'b0000);
        @(negedge clk);
        check("t1_sel", 32'(slave_sel_out), 32'h1);
        check("t1_ready", 32'(ready_out), 32'h1);
        check("t1_data", read_value_out, 32'hDEAD_BEEF);
        check("t1_fault", 32'(fault_out), 32'h0);

        // Back-to-back write to slave2, ready on cycle 3
        write_mask_in = 4'b0011; write_value_in = 32'h0000_A5A5;
        for (int c = 0; c < 4; c++) begin
            next_cycle(); req(0, 1, 32'h2000_0010, (c == 3) ? 4'b0100 : 4'b0000, 4'b0000);
            @(negedge clk);
            check("t2_sel", 32'(slave_sel_out), 32'h4);
            check("t2_ready", 32'(ready_out), (c == 3) ? 32'h1 : 32'h0);
            check("t2_mask", 32'(slave_write_mask_out), 32'h3);
            check("t2_wdata", slave_write_value_out, 32'h0000_A5A5);
        end
        check("t2_fault", 32'(fault_out), 32'h0);
        write_mask_in = 4'hF;

        // Unmapped read
        next_cycle(); req(1, 0, 32'h4000_0000, 4'b1111, 4'b0000);
        @(negedge clk);
        check("t3_ready", 32'(ready_out), 32'h1);
        check("t3_fault", 32'(fault_out), 32'h1);
        check("t3_sel", 32'(slave_sel_out), 32'h0);
        next_cycle(); idle();
        @(negedge clk);
        check("t3_faddr", fault_addr_out, 32'h4000_0000);
        check("t3_fvalid", 32'(fault_valid_out), 32'h1);

        // Timeout on slave3
        for (int c = 0; c <= T + 1; c++) begin
            next_cycle(); req(1, 0, 32'h3000_0004, 4'b0000, 4'b0000);
            @(negedge clk);
            check("t4_sel", 32'(slave_sel_out), (c <= T) ? 32'h8 : 32'h0);
            check("t4_ready", 32'(ready_out), (c <= T) ? 32'h0 : 32'h1);
            check("t4_fault", 32'(fault_out), (c <= T) ? 32'h0 : 32'h1);
        end
        next_cycle(); idle();
        @(negedge clk);
        check("t4_idle_ready", 32'(ready_out), 32'h0);
        check("t4_faddr", fault_addr_out, 32'h3000_0004);

        // Address change while BUSY on slave0 must not reroute
        next_cycle(); req(1, 0, 32'h0000_0100, 4'b0000, 4'b0000);
        next_cycle(); req(1, 0, 32'h1000_0000, 4'b0010, 4'b0000);
        @(negedge clk);
        check("t5_sel_hold", 32'(slave_sel_out), 32'h1);
        check("t5_ready_hold", 32'(ready_out), 32'h0);
        next_cycle(); req(1, 0, 32'h1000_0000, 4'b0011, 4'b0000);
        @(negedge clk);
        check("t5_sel", 32'(slave_sel_out), 32'h1);
        check("t5_data", read_value_out, 32'hDEAD_BEEF);

        // Master abort while BUSY, then a fresh request must time out on full schedule
        next_cycle(); req(1, 0, 32'h2000_0000, 4'b0000, 4'b0000);
        next_cycle(); req(1, 0, 32'h2000_0000, 4'b0000, 4'b0000);
        next_cycle(); idle();
        for (int c = 0; c <= T + 1; c++) begin
            next_cycle(); req(0, 1, 32'h3000_0010, 4'b0000, 4'b0000);
        end
        @(negedge clk);
        check("t6_timeout_ready", 32'(ready_out), 32'h1);
        next_cycle(); idle();

        // Reset while BUSY
        next_cycle(); req(1, 0, 32'h0000_0000, 4'b0000, 4'b0000);
        next_cycle();
        @(negedge clk);
        check("t7_busy_sel", 32'(slave_sel_out), 32'h1);
        next_cycle(); idle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        @(negedge clk);
        check("t7_ready", 32'(ready_out), 32'h0);
        check("t7_fvalid", 32'(fault_valid_out), 32'h0);
        check("t7_wait_cnt", 32'(dut.u_wd.wait_cnt), 32'h0);

        // Slave-signalled fault
        next_cycle(); req(1, 0, 32'h1000_0008, 4'b0010, 4'b0010);
        @(negedge clk);
        check("t8_ready", 32'(ready_out), 32'h1);
        check("t8_fault", 32'(fault_out), 32'h1);
        check("t8_data", read_value_out, 32'h1111_1111);
        next_cycle(); idle();
        @(negedge clk);
        check("t8_faddr", fault_addr_out, 32'h1000_0008);
        check("t8_fvalid", 32'(fault_valid_out), 32'h1);

        next_cycle();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "bench time limit");
    end

endmodule
